spi_flash_responder: RTL and testbench

Synthesizable SPI NOR-flash target that answers the byte-wide SPI port of the APB-to-SPI NOR-flash controller. It decodes opcode, address and data bytes framed by chip select. Write data is stored in an internal 32-bit word array, and read data is returned on `s_miso`. It replaces behavioural flash models in controller benches and serves as an on-chip flash stand-in for FPGA bring-up.

---
 rtl/spi_flash_responder.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash target with a byte-wide SPI port. It answers WRITE (0x02),
// READ (0x01) and ID (0x9F) against a small 32-bit word array. All other
// opcodes are accepted and ignored. Every signal is sampled on p_clk.
module spi_flash_responder #(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] DEV_ID = 32'hEF40_1800
) (
    input  logic       p_clk,
    input  logic       p_reset,
    input  logic       s_clk,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso,
    output logic       wr_done
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IDOUT,
        IGNORE
    } state_t;

    // Input registers and the edge-detect history
    logic        sclk_q;
    logic        sclk_prev_q;
    logic        css_q;
    logic        css_prev_q;
    logic [7:0]  mosi_q;

    // Transaction state
    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        rd_op_q;
    logic [IW-1:0] idx_q;
    logic [31:0] asm_q;
    logic [31:0] rd_word_q;
    logic [31:0] nxt_word_q;
    logic [7:0]  miso_q;
    logic        wr_done_q;
    logic [31:0] mem_q [DEPTH];

    logic          byte_vld;
    logic          css_fall;
    logic [31:0]   a_word;
    logic [IW-1:0] a_idx;

    // A byte counts only when chip select is still low. This lets a
    // simultaneous s_css rise win over an s_clk edge.
    assign byte_vld = sclk_q & ~sclk_prev_q & ~css_q;
    assign css_fall = css_prev_q & ~css_q;
    // Shift view of the assembly register including the byte being captured:
    // the full word in WDATA, and the 24-bit address in its low bits in ADDR.
    assign a_word   = {asm_q[23:0], mosi_q};
    assign a_idx    = a_word[IW+1:2];

    assign s_miso  = miso_q;
    assign wr_done = wr_done_q;

    // Register the SPI pins once. Keep the previous value for edge detection.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            sclk_q      <= 1'b0;
            sclk_prev_q <= 1'b0;
            css_q       <= 1'b0;
            css_prev_q  <= 1'b0;
            mosi_q      <= 8'h00;
        end else begin
            sclk_q      <= s_clk;
            sclk_prev_q <= sclk_q;
            css_q       <= s_css;
            css_prev_q  <= css_q;
            mosi_q      <= s_mosi;
        end
    end

    // Transaction FSM with the array, the read prefetch and the registered outputs
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            rd_op_q    <= 1'b0;
            idx_q      <= '0;
            asm_q      <= 32'h0;
            rd_word_q  <= 32'h0;
            nxt_word_q <= 32'h0;
            miso_q     <= 8'h00;
            wr_done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'hFFFF_FFFF;
            end
        end else begin
            wr_done_q <= 1'b0;
            if (css_q) begin
                // Deselect: abandon any partial word and release MISO.
                state_q <= IDLE;
                cnt_q   <= 2'd0;
                miso_q  <= 8'h00;
            end else if (state_q == IDLE) begin
                // Only a fresh select starts a transaction. This keeps a
                // reset in mid-transaction from resuming on stray bytes.
                if (css_fall) begin
                    state_q <= CMD;
                end
            end else if (byte_vld) begin
                case (state_q)
                    CMD: begin
                        cnt_q  <= 2'd0;
                        miso_q <= 8'h00;
                        case (mosi_q)
                            8'h01: begin
                                rd_op_q <= 1'b1;
                                state_q <= ADDR;
                            end
                            8'h02: begin
                                rd_op_q <= 1'b0;
                                state_q <= ADDR;
                            end
                            8'h9F: begin
                                miso_q  <= DEV_ID[31:24];
                                state_q <= IDOUT;
                            end
                            default: state_q <= IGNORE;
                        endcase
                    end
                    ADDR: begin
                        asm_q <= a_word;
                        if (cnt_q == 2'd2) begin
                            cnt_q <= 2'd0;
                            if (rd_op_q) begin
                                // The first word goes straight out. idx_q then
                                // points at the word to prefetch next.
                                rd_word_q <= mem_q[a_idx];
                                miso_q    <= mem_q[a_idx][31:24];
                                idx_q     <= a_idx + IDX_ONE;
                                state_q   <= RDATA;
                            end else begin
                                idx_q   <= a_idx;
                                state_q <= WDATA;
                            end
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    WDATA: begin
                        asm_q <= a_word;
                        if (cnt_q == 2'd3) begin
                            mem_q[idx_q] <= a_word;
                            wr_done_q    <= 1'b1;
                            idx_q        <= idx_q + IDX_ONE;
                            cnt_q        <= 2'd0;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    RDATA: begin
                        cnt_q <= cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0: begin
                                miso_q     <= rd_word_q[23:16];
                                nxt_word_q <= mem_q[idx_q];
                            end
                            2'd1: miso_q <= rd_word_q[15:8];
                            2'd2: miso_q <= rd_word_q[7:0];
                            default: begin
                                rd_word_q <= nxt_word_q;
                                miso_q    <= nxt_word_q[31:24];
                                idx_q     <= idx_q + IDX_ONE;
                            end
                        endcase
                    end
                    IDOUT: begin
                        case (cnt_q)
                            2'd0:    miso_q <= DEV_ID[23:16];
                            2'd1:    miso_q <= DEV_ID[15:8];
                            2'd2:    miso_q <= DEV_ID[7:0];
                            default: miso_q <= 8'h00;
                        endcase
                        if (cnt_q != 2'd3) begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    default: begin
                        // IGNORE: swallow bytes until deselect.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder. It acts as the SPI controller and
// checks the returned bytes and wr_done pulses against hand-computed values.
module tb_spi_flash_responder;

    localparam int DEPTH = 16;

    logic       p_clk = 1'b0;
    logic       p_reset;
    logic       s_clk;
    logic       s_css;
    logic [7:0] s_mosi;
    logic [7:0] s_miso;
    logic       wr_done;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    spi_flash_responder #(.DEPTH(DEPTH), .DEV_ID(32'hEF40_1800)) dut (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .s_clk   (s_clk),
        .s_css   (s_css),
        .s_mosi  (s_mosi),
        .s_miso  (s_miso),
        .wr_done (wr_done)
    );

    always #5 p_clk = ~p_clk;

    // Count every cycle with wr_done high, so a stretched pulse also shows up.
    always @(posedge p_clk) begin
        if (wr_done) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one byte. rx is what MISO presents just before the rising edge.
    task automatic send(input logic [7:0] tx, output logic [7:0] rx);
        @(negedge p_clk);
        s_mosi = tx;
        repeat (2) @(negedge p_clk);
        rx = s_miso;
        s_clk = 1'b1;
        repeat (4) @(negedge p_clk);
        s_clk = 1'b0;
        repeat (4) @(negedge p_clk);
    endtask

    task automatic cs_low();
        @(negedge p_clk);
        s_css = 1'b0;
        repeat (3) @(negedge p_clk);
    endtask

    task automatic cs_high();
        @(negedge p_clk);
        s_css = 1'b1;
        repeat (4) @(negedge p_clk);
    endtask

    task automatic read_words(input logic [23:0] a, input int n, output logic [63:0] w);
        logic [7:0] rx;
        w = 64'h0;
        cs_low();
        send(8'h01, rx);
        send(a[23:16], rx);
        send(a[15:8], rx);
        send(a[7:0], rx);
        for (int i = 0; i < 4 * n; i++) begin
            send(8'h00, rx);
            w = {w[55:0], rx};
        end
        cs_high();
    endtask

    task automatic send_list(input logic [7:0] b [], output logic [7:0] rx_or);
        logic [7:0] rx;
        rx_or = 8'h00;
        foreach (b[i]) begin
            send(b[i], rx);
            rx_or = rx_or | rx;
        end
    endtask

    initial begin
        logic [63:0] w;
        logic [7:0]  rx;
        logic [7:0]  rx_or;
        int          wr0;

        p_reset = 1'b1;
        s_css   = 1'b1;
        s_clk   = 1'b0;
        s_mosi  = 8'h00;
        repeat (3) @(negedge p_clk);
        p_reset = 1'b0;
        @(negedge p_clk);
        check("reset_miso", {24'h0, s_miso}, 32'h0);
        check("reset_wr_done", {31'h0, wr_done}, 32'h0);

        // Erased array reads back as all ones
        read_words(24'h000000, 1, w);
        check("read_erased", w[31:0], 32'hFFFF_FFFF);
        check("no_wr_done_on_read", wr_cnt, 0);

        // Single word write and read-back
        wr0 = wr_cnt;
        cs_low();
        send_list('{8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00}, rx_or);
        cs_high();
        check("write1_wr_done", wr_cnt - wr0, 1);
        read_words(24'h000000, 1, w);
        check("write1_readback", w[31:0], 32'hFF00_FF00);

        // MISO must be released while deselected; the prefetched next byte would be FF
        check("miso_idle_after_css", {24'h0, s_miso}, 32'h0);

        // Write across the top of the array wraps to word 0
        wr0 = wr_cnt;
        cs_low();
        send_list('{8'h02, 8'h00, 8'h00, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88}, rx_or);
        cs_high();
        check("wrap_wr_done", wr_cnt - wr0, 2);
        read_words(24'h00003C, 2, w);
        check("wrap_read_top", w[63:32], 32'h1122_3344);
        check("wrap_read_word0", w[31:0], 32'h5566_7788);
        read_words(24'h000000, 1, w);
        check("wrap_word0_direct", w[31:0], 32'h5566_7788);

        // Partial word is discarded on deselect
        wr0 = wr_cnt;
        cs_low();
        send_list('{8'h02, 8'h00, 8'h00, 8'h08, 8'hAA, 8'hBB}, rx_or);
        cs_high();
        check("partial_no_wr_done", wr_cnt - wr0, 0);
        read_words(24'h000008, 1, w);
        check("partial_word2", w[31:0], 32'hFFFF_FFFF);

        // Device ID
        cs_low();
        send(8'h9F, rx);
        send(8'h00, rx); check("id_b0", {24'h0, rx}, 32'hEF);
        send(8'h00, rx); check("id_b1", {24'h0, rx}, 32'h40);
        send(8'h00, rx); check("id_b2", {24'h0, rx}, 32'h18);
        send(8'h00, rx); check("id_b3", {24'h0, rx}, 32'h00);
        send(8'h00, rx); check("id_b4", {24'h0, rx}, 32'h00);
        cs_high();

        // Unknown opcode: silent and harmless
        wr0 = wr_cnt;
        cs_low();
        send_list('{8'h7E, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, rx_or);
        cs_high();
        check("ignore_miso", {24'h0, rx_or}, 32'h0);
        check("ignore_no_wr_done", wr_cnt - wr0, 0);
        read_words(24'h000000, 1, w);
        check("ignore_word0", w[31:0], 32'h5566_7788);

        // Reset in the data phase of a write, then keep clocking bytes
        cs_low();
        send_list('{8'h02, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB}, rx_or);
        @(negedge p_clk);
        p_reset = 1'b1;
        @(negedge p_clk);
        p_reset = 1'b0;
        @(negedge p_clk);
        check("midreset_miso", {24'h0, s_miso}, 32'h0);
        wr0 = wr_cnt;
        send_list('{8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78}, rx_or);
        check("midreset_miso_during", {24'h0, rx_or}, 32'h0);
        check("midreset_no_wr_done", wr_cnt - wr0, 0);
        cs_high();
        for (int i = 0; i < DEPTH; i++) begin
            logic [23:0] a;
            a = 24'(4 * i);
            read_words(a, 1, w);
            check($sformatf("midreset_erased_%0d", i), w[31:0], 32'hFFFF_FFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends on its own
    initial begin
        #5ms;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
